writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 22 ++
 rtl/writeback_arbiter_if.sv | 36 +++
 rtl/writeback_arbiter_rr_priority_picker.sv | 28 ++
 rtl/writeback_arbiter.sv | 92 +++++++++
 tb/tb_writeback_arbiter.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter slice (package wb_arb_pkg).
// Build option: WB_ARB_RR_EN selects round-robin arbitration; fixed priority otherwise.
package wb_arb_pkg;

    localparam int NUM_WB_REQ = 4;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int PTR_W      = $clog2(NUM_WB_REQ);

    // Requester slots on the arbitrated writeback port
    typedef enum logic [PTR_W-1:0] {
        WB_LONG_ALU = 2'd0,
        WB_LONG_FPU = 2'd1,
        WB_CACHE    = 2'd2,
        WB_INPUT    = 2'd3
    } wb_req_id_e;

    // wb_src codes beyond the requester indices
    localparam logic [2:0] WB_SRC_SHORT = 3'd4;
    localparam logic [2:0] WB_SRC_NONE  = 3'd7;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bus: short ALU input, arbitrated requesters, and register file write port.
interface writeback_arbiter_if;
    import wb_arb_pkg::*;

    logic                                       short_wb_valid;
    logic                                       short_wb_fpu;
    logic [REG_ADDR_W-1:0]                      short_wb_rd;
    logic [XLEN-1:0]                            short_wb_data;
    logic [NUM_WB_REQ-1:0]                      req_valid;
    logic [NUM_WB_REQ-1:0]                      req_fpu;
    logic [NUM_WB_REQ-1:0][REG_ADDR_W-1:0]      req_rd;
    logic [NUM_WB_REQ-1:0][XLEN-1:0]            req_data;
    logic [NUM_WB_REQ-1:0]                      req_ready;
    logic                                       wb_reg_write;
    logic                                       wb_fpu_reg_write;
    logic [REG_ADDR_W-1:0]                      wb_rd;
    logic [XLEN-1:0]                            wb_data;
    logic [2:0]                                 wb_src;

    // Producers and register file side
    modport master (
        output short_wb_valid, short_wb_fpu, short_wb_rd, short_wb_data,
        output req_valid, req_fpu, req_rd, req_data,
        input  req_ready,
        input  wb_reg_write, wb_fpu_reg_write, wb_rd, wb_data, wb_src
    );

    // Arbiter side
    modport slave (
        input  short_wb_valid, short_wb_fpu, short_wb_rd, short_wb_data,
        input  req_valid, req_fpu, req_rd, req_data,
        output req_ready,
        output wb_reg_write, wb_fpu_reg_write, wb_rd, wb_data, wb_src
    );

endinterface

// File: rtl/writeback_arbiter_rr_priority_picker.sv
// Rotating-priority picker: grants the first valid requester found starting at ptr.
// With ptr tied to 0 it degenerates to fixed priority, index 0 highest.
module rr_priority_picker
    import wb_arb_pkg::*;
(
    input  logic [NUM_WB_REQ-1:0] valid,
    input  logic [PTR_W-1:0]      ptr,
    output logic [NUM_WB_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk ptr, ptr+1, ... modulo NUM_WB_REQ and take the first valid slot
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_WB_REQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: short ALU result preempts; long requesters share the port.
// Build option: WB_ARB_RR_EN enables the round-robin pointer; otherwise fixed priority.
module writeback_arbiter
    import wb_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    writeback_arbiter_if.slave  bus
);

    logic [NUM_WB_REQ-1:0] pick_valid;
    logic [NUM_WB_REQ-1:0] grant;
    logic [PTR_W-1:0]      pick_ptr;
    logic [PTR_W-1:0]      grant_idx;

    logic                  wb_reg_write_p1;
    logic                  wb_fpu_reg_write_p1;
    logic [REG_ADDR_W-1:0] wb_rd_p1;
    logic [XLEN-1:0]       wb_data_p1;
    logic [2:0]            wb_src_p1;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_WB_REQ-1:0] oh);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_WB_REQ; i++) begin
            if (oh[i]) r = r | PTR_W'(i);
        end
        return r;
    endfunction

    // Requests are masked during reset and whenever the short ALU owns the port
    assign pick_valid    = (rst || bus.short_wb_valid) ? '0 : bus.req_valid;
    assign bus.req_ready = grant;
    assign grant_idx     = onehot_to_idx(grant);

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] ptr;

    // Advance priority past the last winner; hold on idle or preempted cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= grant_idx + PTR_W'(1);
        end
    end

    assign pick_ptr = ptr;
`else
    assign pick_ptr = '0;
`endif

    rr_priority_picker u_picker (
        .valid (pick_valid),
        .ptr   (pick_ptr),
        .grant (grant)
    );

    // Register the winning result; rd/data hold when nothing is written
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg_write_p1     <= 1'b0;
            wb_fpu_reg_write_p1 <= 1'b0;
            wb_rd_p1            <= '0;
            wb_data_p1          <= '0;
            wb_src_p1           <= WB_SRC_NONE;
        end else if (bus.short_wb_valid) begin
            wb_reg_write_p1     <= !bus.short_wb_fpu && (bus.short_wb_rd != '0);
            wb_fpu_reg_write_p1 <= bus.short_wb_fpu;
            wb_rd_p1            <= bus.short_wb_rd;
            wb_data_p1          <= bus.short_wb_data;
            wb_src_p1           <= WB_SRC_SHORT;
        end else if (|grant) begin
            wb_reg_write_p1     <= !bus.req_fpu[grant_idx] && (bus.req_rd[grant_idx] != '0);
            wb_fpu_reg_write_p1 <= bus.req_fpu[grant_idx];
            wb_rd_p1            <= bus.req_rd[grant_idx];
            wb_data_p1          <= bus.req_data[grant_idx];
            wb_src_p1           <= {1'b0, grant_idx};
        end else begin
            wb_reg_write_p1     <= 1'b0;
            wb_fpu_reg_write_p1 <= 1'b0;
            wb_src_p1           <= WB_SRC_NONE;
        end
    end

    assign bus.wb_reg_write     = wb_reg_write_p1;
    assign bus.wb_fpu_reg_write = wb_fpu_reg_write_p1;
    assign bus.wb_rd            = wb_rd_p1;
    assign bus.wb_data          = wb_data_p1;
    assign bus.wb_src           = wb_src_p1;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; RR checks apply when WB_ARB_RR_EN is defined.
module tb_writeback_arbiter;
    import wb_arb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    writeback_arbiter_if bus ();

    writeback_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic rw, input logic fw,
                          input logic [4:0] rd, input logic [31:0] data, input logic [2:0] src);
        chk({tag, ".reg_write"}, 32'(bus.wb_reg_write), 32'(rw));
        chk({tag, ".fpu_write"}, 32'(bus.wb_fpu_reg_write), 32'(fw));
        chk({tag, ".rd"},        32'(bus.wb_rd), 32'(rd));
        chk({tag, ".data"},      bus.wb_data, data);
        chk({tag, ".src"},       32'(bus.wb_src), 32'(src));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.short_wb_valid = 1'b0;
        bus.short_wb_fpu   = 1'b0;
        bus.short_wb_rd    = '0;
        bus.short_wb_data  = '0;
        bus.req_valid      = '0;
        bus.req_fpu        = '0;
        for (int i = 0; i < NUM_WB_REQ; i++) begin
            bus.req_rd[i]   = 5'(i + 4);
            bus.req_data[i] = 32'hA0 + 32'(i);
        end

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0, 3'd7);
        chk("reset.ready", 32'(bus.req_ready), 32'h0);

        // Contention among requesters
        @(negedge clk);
        rst = 1'b0;
`ifdef WB_ARB_RR_EN
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1 chk("rr.ready", 32'(bus.req_ready), 32'(4'b0001 << c));
            @(posedge clk); #1;
            chk_wb("rr.wb", 1'b1, 1'b0, 5'(c + 4), 32'hA0 + 32'(c), 3'(c));
            @(negedge clk);
        end
        chk("rr.ptr_wrap", 32'(dut.ptr), 32'h0);
`else
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            #1 chk("fixed.ready", 32'(bus.req_ready), 32'h2);
            @(posedge clk); #1;
            chk_wb("fixed.wb", 1'b1, 1'b0, 5'd5, 32'hA1, 3'd1);
            @(negedge clk);
        end
        bus.req_valid = 4'b1111;
        #1 chk("fixed.all_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
`endif
        bus.req_valid = 4'b0000;

        // Short ALU preempts requester 0, which is served the next cycle
        @(negedge clk);
        bus.short_wb_valid = 1'b1;
        bus.short_wb_rd    = 5'd3;
        bus.short_wb_data  = 32'h11;
        bus.req_valid      = 4'b0001;
        bus.req_rd[0]      = 5'd7;
        #1 chk("short.ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        chk_wb("short.wb", 1'b1, 1'b0, 5'd3, 32'h11, 3'd4);
        @(negedge clk);
        bus.short_wb_valid = 1'b0;
        #1 chk("after_short.ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        chk_wb("after_short.wb", 1'b1, 1'b0, 5'd7, 32'hA0, 3'd0);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk_wb("idle.hold", 1'b0, 1'b0, 5'd7, 32'hA0, 3'd7);

        // Integer write to x0 is suppressed, fields still update
        @(negedge clk);
        bus.req_valid   = 4'b0100;
        bus.req_fpu[2]  = 1'b0;
        bus.req_rd[2]   = 5'd0;
        bus.req_data[2] = 32'hDEAD;
        #1 chk("x0.ready", 32'(bus.req_ready), 32'h4);
        @(posedge clk); #1;
        chk_wb("x0.wb", 1'b0, 1'b0, 5'd0, 32'hDEAD, 3'd2);

        // FPU write to f0 is allowed
        @(negedge clk);
        bus.req_valid   = 4'b0010;
        bus.req_fpu[1]  = 1'b1;
        bus.req_rd[1]   = 5'd0;
        bus.req_data[1] = 32'h5;
        #1 chk("f0.ready", 32'(bus.req_ready), 32'h2);
        @(posedge clk); #1;
        chk_wb("f0.wb", 1'b0, 1'b1, 5'd0, 32'h5, 3'd1);

        // Reset with requester 2 pending: no grant during reset, served once afterwards
        @(negedge clk);
        rst             = 1'b1;
        bus.req_valid   = 4'b0100;
        bus.req_fpu     = 4'b0000;
        bus.req_rd[2]   = 5'd9;
        bus.req_data[2] = 32'hBEEF;
        #1 chk("rst.ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        chk_wb("rst.wb", 1'b0, 1'b0, 5'd0, 32'h0, 3'd7);
`ifdef WB_ARB_RR_EN
        chk("rst.ptr", 32'(dut.ptr), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst.ready", 32'(bus.req_ready), 32'h4);
        @(posedge clk); #1;
        chk_wb("post_rst.wb", 1'b1, 1'b0, 5'd9, 32'hBEEF, 3'd2);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        chk_wb("post_rst.once", 1'b0, 1'b0, 5'd9, 32'hBEEF, 3'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
